// File: rtl/reg_file_writeback_pkg.sv
// Shared definitions for the GPR file, its WB write side and the load-use scoreboard.
package reg_file_writeback_pkg;

    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned ADDR_WIDTH   = 5;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned REG_ADDR_BUS = ADDR_WIDTH;
    localparam int unsigned DATA_BUS     = DATA_WIDTH;
    localparam int unsigned COUNT_WIDTH  = 32;

    localparam logic READ_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b0;

    localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic                    en;
        logic [REG_ADDR_BUS-1:0] addr;
        logic [DATA_BUS-1:0]     data;
    } wb_write_t;

    // A read port must wait if its source is owned by an unfinished load.
    function automatic logic port_hit(
        input logic                    en,
        input logic [REG_ADDR_BUS-1:0] addr,
        input logic                    pending_bit,
        input logic                    wb_en,
        input logic [REG_ADDR_BUS-1:0] wb_addr,
        input logic                    ld_set,
        input logic [REG_ADDR_BUS-1:0] ld_addr
    );
        logic wb_covers;
        logic ld_match;
        wb_covers = (wb_en == WRITE_ENABLE) && (wb_addr == addr);
        ld_match  = ld_set && (ld_addr == addr);
        return (en == READ_ENABLE) && (addr != '0) &&
               ((pending_bit && !wb_covers) || ld_match);
    endfunction

endpackage

// File: rtl/reg_file_writeback_load_scoreboard.sv
// Pending-load scoreboard: tracks load destinations between EX and WB and flags load-use hazards.
module load_scoreboard
    import reg_file_writeback_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_write_en,
    input  logic [REG_ADDR_BUS-1:0] wb_write_addr,
    input  logic                    ex_load_en,
    input  logic [REG_ADDR_BUS-1:0] ex_load_addr,
    input  logic                    flush,
    input  logic                    read_en_1,
    input  logic [REG_ADDR_BUS-1:0] read_addr_1,
    input  logic                    read_en_2,
    input  logic [REG_ADDR_BUS-1:0] read_addr_2,
    output logic                    stall_req_c
);

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] pending_next;
    logic               load_set;
    logic               hit_1;
    logic               hit_2;

    // Set is applied after clear so the younger load keeps ownership.
    always_comb begin
        pending_next = pending;
        load_set     = ex_load_en && !flush && (ex_load_addr != '0);
        if (wb_write_en == WRITE_ENABLE) begin
            pending_next[wb_write_addr] = 1'b0;
        end
        if (load_set) begin
            pending_next[ex_load_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;

        hit_1 = port_hit(read_en_1, read_addr_1, pending[read_addr_1],
                         wb_write_en, wb_write_addr, load_set, ex_load_addr);
        hit_2 = port_hit(read_en_2, read_addr_2, pending[read_addr_2],
                         wb_write_en, wb_write_addr, load_set, ex_load_addr);
        stall_req_c = (rst != RST_ENABLE) && (hit_1 || hit_2);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/reg_file_writeback.sv
// Architectural GPR file with WB write-through bypass, load-use interlock and stall counter.
module reg_file_writeback
    import reg_file_writeback_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_write_en,
    input  logic [REG_ADDR_BUS-1:0] wb_write_addr,
    input  logic [DATA_BUS-1:0]     wb_write_data,
    input  logic                    read_en_1,
    input  logic [REG_ADDR_BUS-1:0] read_addr_1,
    output logic [DATA_BUS-1:0]     read_data_1,
    input  logic                    read_en_2,
    input  logic [REG_ADDR_BUS-1:0] read_addr_2,
    output logic [DATA_BUS-1:0]     read_data_2,
    input  logic                    ex_load_en,
    input  logic [REG_ADDR_BUS-1:0] ex_load_addr,
    input  logic                    flush,
    output logic                    stall_req,
    output logic [COUNT_WIDTH-1:0]  stall_count
);

    logic [DATA_BUS-1:0] regs [REG_NUM];
    wb_write_t           wb;
    logic                stall_req_c;

    assign wb = '{en: wb_write_en, addr: wb_write_addr, data: wb_write_data};

    function automatic logic [DATA_BUS-1:0] read_mux(
        input logic                    in_reset,
        input logic                    en,
        input logic [REG_ADDR_BUS-1:0] addr,
        input wb_write_t               w,
        input logic [DATA_BUS-1:0]     stored
    );
        if (in_reset || (en != READ_ENABLE) || (addr == '0)) begin
            return ZERO_WORD;
        end
        if ((w.en == WRITE_ENABLE) && (w.addr == addr)) begin
            return w.data;
        end
        return stored;
    endfunction

    always_comb begin
        read_data_1 = read_mux(rst == RST_ENABLE, read_en_1, read_addr_1, wb, regs[read_addr_1]);
        read_data_2 = read_mux(rst == RST_ENABLE, read_en_2, read_addr_2, wb, regs[read_addr_2]);
    end

    load_scoreboard u_load_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wb_write_en   (wb_write_en),
        .wb_write_addr (wb_write_addr),
        .ex_load_en    (ex_load_en),
        .ex_load_addr  (ex_load_addr),
        .flush         (flush),
        .read_en_1     (read_en_1),
        .read_addr_1   (read_addr_1),
        .read_en_2     (read_en_2),
        .read_addr_2   (read_addr_2),
        .stall_req_c   (stall_req_c)
    );

    assign stall_req = stall_req_c;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= ZERO_WORD;
            end
            stall_count <= '0;
        end else begin
            if ((wb.en == WRITE_ENABLE) && (wb.addr != '0)) begin
                regs[wb.addr] <= wb.data;
            end
            if (stall_req_c && (stall_count != '1)) begin
                stall_count <= stall_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule
